// File: rtl/hbm_delay_stamp.sv
// hbm_delay_stamp: ingress stage of the HBM latency model that stamps NoC flits with a release time.
// Accepts OpenPiton memory-request packets, decodes the channel group from the address flit,
// and writes {flit, head, tail, exp_time} words to the delay FIFO; exp_time = accept time + group latency.
// Optional macro HBM_DELAY_STATS_EN adds saturating packet/flit counters (o_stat_pkts, o_stat_flits).
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   i_in_val     input flit valid
//   i_in_data    input flit
//   o_in_rdy     input flit accepted when i_in_val & o_in_rdy
//   o_out_val    stamped word valid
//   o_out_data   {flit, head, tail, exp_time}, exp_time in the LSBs
//   i_out_rdy    delay FIFO not full
//   o_timer      free-running model timer shared with the release stage
//   o_stat_pkts  packets written (HBM_DELAY_STATS_EN only)
//   o_stat_flits flits written (HBM_DELAY_STATS_EN only)
module hbm_delay_stamp #(
    parameter int NOC_DW         = 64,
    parameter int TIMERw         = 32,
    parameter int CHAN_GROUP     = 8,
    parameter int CHAN_GROUPw    = 3,
    parameter int CHAN_BASE_ADDR = 30,
    parameter int ADDR_W         = 40,
    parameter int LEN_LSB        = 22,
    parameter int LEN_W          = 8,
    parameter logic [CHAN_GROUP*TIMERw-1:0] DELAYS = {8{32'd100}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_in_val,
    input  logic [NOC_DW-1:0]        i_in_data,
    output logic                     o_in_rdy,
    output logic                     o_out_val,
    output logic [NOC_DW+TIMERw+1:0] o_out_data,
    input  logic                     i_out_rdy,
    output logic [TIMERw-1:0]        o_timer
`ifdef HBM_DELAY_STATS_EN
    ,
    output logic [31:0]              o_stat_pkts,
    output logic [31:0]              o_stat_flits
`endif
);
    typedef enum logic [2:0] {IDLE, WAIT_ADDR, EMIT_HDR, EMIT_ADDR, BODY} state_t;

    if (CHAN_BASE_ADDR + CHAN_GROUPw > ADDR_W) begin : g_bad_field
        $error("group-index field lies outside the address field");
    end

    state_t                  r_state, w_next;
    logic [TIMERw-1:0]       r_timer, r_exp;
    logic [NOC_DW-1:0]       r_hdr, r_addr;
    logic [LEN_W-1:0]        r_len, r_rem;
    logic [LEN_W-1:0]        w_len;
    logic [CHAN_GROUPw-1:0]  w_grp;
    logic [TIMERw-1:0]       w_delay;
    logic [NOC_DW-1:0]       w_flit;
    logic                    w_head, w_tail, w_out_hs;

    assign w_len    = i_in_data[LEN_LSB +: LEN_W];
    assign w_grp    = i_in_data[CHAN_BASE_ADDR +: CHAN_GROUPw];
    assign w_delay  = DELAYS[w_grp*TIMERw +: TIMERw];
    assign w_out_hs = o_out_val & i_out_rdy;
    assign o_timer  = r_timer;
    assign o_out_data = o_out_val ? {w_flit, w_head, w_tail, r_exp} : '0;

    always_comb begin
        w_next    = r_state;
        o_in_rdy  = 1'b0;
        o_out_val = 1'b0;
        w_flit    = '0;
        w_head    = 1'b0;
        w_tail    = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_rdy = 1'b1;
                if (i_in_val) w_next = (w_len == '0) ? EMIT_HDR : WAIT_ADDR;
            end
            WAIT_ADDR: begin
                o_in_rdy = 1'b1;
                if (i_in_val) w_next = EMIT_HDR;
            end
            EMIT_HDR: begin
                o_out_val = 1'b1;
                w_flit    = r_hdr;
                w_head    = 1'b1;
                w_tail    = (r_len == '0);
                if (i_out_rdy) w_next = (r_len == '0) ? IDLE : EMIT_ADDR;
            end
            EMIT_ADDR: begin
                o_out_val = 1'b1;
                w_flit    = r_addr;
                w_tail    = (r_len == LEN_W'(1));
                if (i_out_rdy) w_next = (r_len == LEN_W'(1)) ? IDLE : BODY;
            end
            BODY: begin
                // body flits bypass the registers, so they add no latency
                o_in_rdy  = i_out_rdy;
                o_out_val = i_in_val;
                w_flit    = i_in_data;
                w_tail    = (r_rem == LEN_W'(1));
                if (i_in_val && i_out_rdy && r_rem == LEN_W'(1)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // hold the handshake signals low while reset is asserted
        if (reset) begin
            o_in_rdy  = 1'b0;
            o_out_val = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
            r_exp   <= '0;
            r_hdr   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_rem   <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
            // r_exp holds t0 until the address flit supplies the group latency
            if (r_state == IDLE && i_in_val) begin
                r_hdr <= i_in_data;
                r_len <= w_len;
                r_exp <= (w_len == '0) ? r_timer + DELAYS[TIMERw-1:0] : r_timer;
            end
            if (r_state == WAIT_ADDR && i_in_val) begin
                r_addr <= i_in_data;
                r_exp  <= r_exp + w_delay;
            end
            if (r_state == EMIT_ADDR && i_out_rdy) r_rem <= r_len - 1'b1;
            if (r_state == BODY && w_out_hs) r_rem <= r_rem - 1'b1;
        end
    end

`ifdef HBM_DELAY_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_stat_pkts  <= '0;
            o_stat_flits <= '0;
        end else begin
            if (w_out_hs && o_stat_flits != '1) o_stat_flits <= o_stat_flits + 1'b1;
            if (w_out_hs && w_tail && o_stat_pkts != '1) o_stat_pkts <= o_stat_pkts + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hbm_delay_stamp.sv
// tb_hbm_delay_stamp: randomized scoreboard bench for hbm_delay_stamp.
module tb_hbm_delay_stamp;
    localparam logic [255:0] DL = {32'hFFFF_FFF0, 32'd250, 32'd201, 32'd150,
                                   32'd77, 32'd60, 32'd100, 32'd37};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_in_val = 1'b0;
    logic [63:0] i_in_data = '0;
    logic        i_out_rdy = 1'b1;
    logic        o_in_rdy, o_out_val;
    logic [97:0] o_out_data;
    logic [31:0] o_timer;
`ifdef HBM_DELAY_STATS_EN
    logic [31:0] o_stat_pkts, o_stat_flits;
`endif

    hbm_delay_stamp #(.DELAYS(DL)) dut (
        .clk(clk), .reset(reset), .i_in_val(i_in_val), .i_in_data(i_in_data),
        .o_in_rdy(o_in_rdy), .o_out_val(o_out_val), .o_out_data(o_out_data),
        .i_out_rdy(i_out_rdy), .o_timer(o_timer)
`ifdef HBM_DELAY_STATS_EN
        , .o_stat_pkts(o_stat_pkts), .o_stat_flits(o_stat_flits)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [97:0] w;
        bit          exact;
        int unsigned at;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0, popped = 0;
    int unsigned cyc = 0;
    bit          rnd = 0, stall = 0, gaps = 0;
    int unsigned dly[8] = '{37, 100, 60, 77, 150, 201, 250, 32'hFFFF_FFF0};

    // reference timer: counts cycles since reset release
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        i_out_rdy = stall ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    exp_t        e;
    bit          hold = 0;
    logic [97:0] hold_d;
    initial forever begin
        @(negedge clk);
        #2;
        if (reset) begin
            hold = 0;
            continue;
        end
        if (hold) begin
            chk("hold_val", o_out_val, 1);
            chk("hold_data", o_out_data, hold_d);
        end
        if (o_out_val && i_out_rdy) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", o_out_data);
            end else begin
                e = q.pop_front();
                chk("word", o_out_data, e.w);
                if (e.exact) chk("latency", cyc, e.at);
                chk("timer", o_timer, cyc);
                popped++;
            end
        end
        hold   = o_out_val && !i_out_rdy;
        hold_d = o_out_data;
    end

    task automatic send(input int len, input logic [39:0] addr, input int nmax);
        logic [63:0] f[$];
        logic [63:0] t;
        int unsigned t0, ex;
        int          g, n;
        t = {$urandom, $urandom};
        t[29:22] = len[7:0];
        f.push_back(t);
        if (len > 0) begin
            t = {$urandom, $urandom};
            t[39:0] = addr;
            f.push_back(t);
        end
        for (int i = 2; i <= len; i++) f.push_back({$urandom, $urandom});
        g = (len == 0) ? 0 : int'(addr[32:30]);
        for (int i = 0; i < f.size() && i < nmax; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    i_in_val = 1'b0;
                end
            end
            n = 0;
            do begin
                @(negedge clk);
                i_in_val  = 1'b1;
                i_in_data = f[i];
                #2;
                n++;
            end while (!o_in_rdy && n < 200);
            if (!o_in_rdy) begin
                checks++;
                errors++;
                $display("FAIL in_rdy_timeout: got 0 expected 1 (flit %0d)", i);
                break;
            end
            if (i == 0) begin
                t0 = cyc;
                ex = t0 + dly[g];
                for (int j = 0; j <= len; j++)
                    q.push_back('{w: {f[j], 1'(j == 0), 1'(j == len), ex},
                                  exact: (j == 0 && !rnd && !gaps),
                                  at: t0 + ((len == 0) ? 1 : 2)});
            end
        end
        @(negedge clk);
        i_in_val = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d words pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        i_in_val = 1'b0;
        stall    = 0;
        q.delete();
        @(negedge clk);
        #2;
        chk("rst_out_val", o_out_val, 0);
        chk("rst_in_rdy", o_in_rdy, 0);
        chk("rst_timer", o_timer, 0);
        chk("rst_out_data", o_out_data, 0);
`ifdef HBM_DELAY_STATS_EN
        chk("rst_stat_pkts", o_stat_pkts, 0);
        chk("rst_stat_flits", o_stat_flits, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        chk("post_rst_in_rdy", o_in_rdy, 1);
        chk("post_rst_timer", o_timer, cyc);
    endtask

    task automatic wait_cyc(input int unsigned c);
        int n = 0;
        while (cyc != c && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int p0;
        do_reset();
        // 3-flit packet accepted at timer 10, group 1
        wait_cyc(9);
        send(2, 40'h0_4000_0000, 99);
        drain();
        // header-only packet accepted at timer 5
        do_reset();
        wait_cyc(4);
        send(0, 40'h0, 99);
        drain();
        // 7-cycle stall while the address flit is presented
        p0 = popped;
        fork
            send(3, 40'h0_8000_1234, 99);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk);
                    #1;
                    if (popped > p0) break;
                end
                stall = 1;
                repeat (7) begin
                    @(negedge clk);
                    #3;
                    chk("stall_in_rdy", o_in_rdy, 0);
                    chk("stall_out_val", o_out_val, 1);
                end
                stall = 0;
            end
        join
        drain();
        // exp_time wraps modulo 2^32, then upper address bits alias
        send(2, 40'h1_C000_0000, 99);
        send(1, 40'hA_4000_0000, 99);
        drain();
        // randomized traffic with gaps and backpressure
        rnd  = 1;
        gaps = 1;
        for (int k = 0; k < 40; k++)
            send($urandom_range(0, 9), {$urandom_range(0, 255), $urandom}, 99);
        drain();
        // reset while in BODY with 3 flits outstanding
        rnd  = 0;
        gaps = 0;
        send(5, 40'h0_C000_0000, 3);
        do_reset();
        send(2, {$urandom_range(0, 255), $urandom}, 99);
        drain();
`ifdef HBM_DELAY_STATS_EN
        do_reset();
        rnd = 1;
        send(0, 40'h0, 99);
        send(1, 40'h0_4000_0000, 99);
        send(2, 40'h1_0000_0000, 99);
        send(8, 40'h1_8000_0000, 99);
        drain();
        repeat (2) @(negedge clk);
        chk("stat_pkts", o_stat_pkts, 4);
        chk("stat_flits", o_stat_flits, 15);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
